// File: rtl/ps2_key_decoder_if.sv
// Key-event bus from the PS/2 decoder to its consumer.
// master drives ascii/scan_code/key_valid/frame_err/parity_err; slave observes.
interface ps2_key_decoder_if;
    logic [6:0] ascii;
    logic [7:0] scan_code;
    logic       key_valid;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output ascii,
        output scan_code,
        output key_valid,
        output frame_err,
        output parity_err
    );

    modport slave (
        input ascii,
        input scan_code,
        input key_valid,
        input frame_err,
        input parity_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames set-2 bytes, tracks make/break, maps to ASCII.
// Ports: CLOCK_50, reset (sync, high), PS2_KBCLK/PS2_KBDAT (async), keyBus (master).
module ps2_key_decoder #(
    parameter int FRAME_TIMEOUT = 50000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                PS2_KBCLK,
    input  logic                PS2_KBDAT,
    ps2_key_decoder_if.master   keyBus
);

    localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t nextState;

    logic clkMeta, clkSync, clkPrev;
    logic datMeta, datSync;
    logic detect;
    logic dat;

    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          parityBit;
    logic [TW-1:0] timer;
    logic          timedOut;

    logic frameErrC;
    logic parityErrC;
    logic acceptC;

    logic       byteReady;
    logic [7:0] byteReg;

    logic       extFlag;
    logic       brkFlag;
    logic [6:0] asciiR;
    logic [7:0] scanR;
    logic       keyValidR;
    logic [6:0] mapped;

    function automatic logic [6:0] asciiOf(input logic [7:0] code);
        logic [6:0] a;
        a = 7'h00;
        case (code)
            8'h1C: a = 7'h61;
            8'h32: a = 7'h62;
            8'h21: a = 7'h63;
            8'h23: a = 7'h64;
            8'h24: a = 7'h65;
            8'h2B: a = 7'h66;
            8'h34: a = 7'h67;
            8'h33: a = 7'h68;
            8'h43: a = 7'h69;
            8'h3B: a = 7'h6A;
            8'h42: a = 7'h6B;
            8'h4B: a = 7'h6C;
            8'h3A: a = 7'h6D;
            8'h31: a = 7'h6E;
            8'h44: a = 7'h6F;
            8'h4D: a = 7'h70;
            8'h15: a = 7'h71;
            8'h2D: a = 7'h72;
            8'h1B: a = 7'h73;
            8'h2C: a = 7'h74;
            8'h3C: a = 7'h75;
            8'h2A: a = 7'h76;
            8'h1D: a = 7'h77;
            8'h22: a = 7'h78;
            8'h35: a = 7'h79;
            8'h1A: a = 7'h7A;
            8'h29: a = 7'h20;
            default: a = 7'h00;
        endcase
        return a;
    endfunction

    // Synchronizers idle at 1 so a released bus never looks like an edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clkMeta <= 1'b1;
            clkSync <= 1'b1;
            clkPrev <= 1'b1;
            datMeta <= 1'b1;
            datSync <= 1'b1;
        end else begin
            clkMeta <= PS2_KBCLK;
            clkSync <= clkMeta;
            clkPrev <= clkSync;
            datMeta <= PS2_KBDAT;
            datSync <= datMeta;
        end
    end

    assign detect   = clkPrev & ~clkSync;
    assign dat      = datSync;
    assign timedOut = (state != IDLE) && !detect && (timer == TIMEOUT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (timedOut) begin
            nextState = IDLE;
        end else if (detect) begin
            unique case (state)
                IDLE:   nextState = dat ? IDLE : DATA;
                DATA:   nextState = (bitCnt == 3'd7) ? PARITY : DATA;
                PARITY: nextState = STOP;
                STOP:   nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        frameErrC  = 1'b0;
        parityErrC = 1'b0;
        acceptC    = 1'b0;
        if (timedOut) begin
            frameErrC = 1'b1;
        end else if (detect) begin
            case (state)
                IDLE: frameErrC = dat;
                STOP: begin
                    if (!dat) begin
                        frameErrC = 1'b1;
                    end else if (!(^{shiftReg, parityBit})) begin
                        parityErrC = 1'b1;
                    end else begin
                        acceptC = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bitCnt    <= 3'd0;
            shiftReg  <= 8'h00;
            parityBit <= 1'b0;
            timer     <= '0;
            byteReady <= 1'b0;
            byteReg   <= 8'h00;
        end else begin
            if (state == IDLE || detect || timedOut) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if (detect) begin
                case (state)
                    IDLE: begin
                        bitCnt   <= 3'd0;
                        shiftReg <= 8'h00;
                    end
                    DATA: begin
                        shiftReg <= {dat, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                    end
                    PARITY: parityBit <= dat;
                    default: ;
                endcase
            end
            byteReady <= acceptC;
            byteReg   <= shiftReg;
        end
    end

    assign mapped = asciiOf(byteReg);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            extFlag   <= 1'b0;
            brkFlag   <= 1'b0;
            asciiR    <= 7'h00;
            scanR     <= 8'h00;
            keyValidR <= 1'b0;
        end else begin
            keyValidR <= 1'b0;
            if (byteReady) begin
                if (byteReg == 8'hE0) begin
                    extFlag <= 1'b1;
                end else if (byteReg == 8'hF0) begin
                    brkFlag <= 1'b1;
                end else if (brkFlag) begin
                    // Only releasing the currently shown key clears it.
                    if (byteReg == scanR) begin
                        asciiR <= 7'h00;
                        scanR  <= 8'h00;
                    end
                    brkFlag <= 1'b0;
                    extFlag <= 1'b0;
                end else if (extFlag) begin
                    extFlag <= 1'b0;
                end else if (mapped != 7'h00 && byteReg != scanR) begin
                    asciiR    <= mapped;
                    scanR     <= byteReg;
                    keyValidR <= 1'b1;
                end
            end
        end
    end

    // key_valid wins if an error edge ever lands in its cycle.
    assign keyBus.ascii      = asciiR;
    assign keyBus.scan_code  = scanR;
    assign keyBus.key_valid  = keyValidR;
    assign keyBus.frame_err  = frameErrC & ~reset & ~keyValidR;
    assign keyBus.parity_err = parityErrC & ~reset & ~keyValidR;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder.
// Drives PS/2 frames bit by bit and checks keys, pulses and latencies.
module tb_ps2_key_decoder;

    localparam int FT   = 100;
    localparam int HALF = 10;

    logic CLOCK_50  = 1'b0;
    logic reset     = 1'b1;
    logic PS2_KBCLK = 1'b1;
    logic PS2_KBDAT = 1'b1;

    ps2_key_decoder_if kb ();

    ps2_key_decoder #(.FRAME_TIMEOUT(FT)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_KBCLK (PS2_KBCLK),
        .PS2_KBDAT (PS2_KBDAT),
        .keyBus    (kb)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc     = 0;
    int checks  = 0;
    int fails   = 0;
    int kvCount = 0;
    int feCount = 0;
    int peCount = 0;
    int kvCyc   = 0;
    int feCyc   = 0;
    int peCyc   = 0;
    int fallCyc = 0;
    int overlap = 0;
    int wide    = 0;
    logic prevKv = 1'b0;
    logic prevFe = 1'b0;
    logic prevPe = 1'b0;

    always @(posedge CLOCK_50) cyc = cyc + 1;

    always @(negedge CLOCK_50) begin
        if (kb.key_valid) begin
            kvCount = kvCount + 1;
            kvCyc   = cyc;
        end
        if (kb.frame_err) begin
            feCount = feCount + 1;
            feCyc   = cyc;
        end
        if (kb.parity_err) begin
            peCount = peCount + 1;
            peCyc   = cyc;
        end
        if (int'(kb.key_valid) + int'(kb.frame_err) + int'(kb.parity_err) > 1)
            overlap = overlap + 1;
        if ((kb.key_valid && prevKv) || (kb.frame_err && prevFe) ||
            (kb.parity_err && prevPe))
            wide = wide + 1;
        prevKv = kb.key_valid;
        prevFe = kb.frame_err;
        prevPe = kb.parity_err;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2Bit(input logic b);
        PS2_KBDAT = b;
        repeat (HALF) @(posedge CLOCK_50);
        #1 PS2_KBCLK = 1'b0;
        fallCyc = cyc;
        repeat (HALF) @(posedge CLOCK_50);
        #1 PS2_KBCLK = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic flipPar,
                             input logic stopBit);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(b[i]);
        ps2Bit((~^b) ^ flipPar);
        ps2Bit(stopBit);
        PS2_KBDAT = 1'b1;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    initial begin
        logic [7:0] part;
        part = 8'h1C;
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_ascii", kb.ascii, 0);
        check("rst_scan", kb.scan_code, 0);
        check("rst_kv", kb.key_valid, 0);
        check("rst_fe", kb.frame_err, 0);
        check("rst_pe", kb.parity_err, 0);

        sendFrame(8'h1C, 1'b0, 1'b1);
        check("a_ascii", kb.ascii, 'h61);
        check("a_scan", kb.scan_code, 'h1C);
        check("a_kvcnt", kvCount, 1);
        check("a_kvlat", kvCyc - fallCyc, 4);

        sendFrame(8'h1C, 1'b0, 1'b1);
        check("rep_kvcnt", kvCount, 1);
        check("rep_ascii", kb.ascii, 'h61);
        sendFrame(8'hF0, 1'b0, 1'b1);
        check("f0_ascii", kb.ascii, 'h61);
        sendFrame(8'h1C, 1'b0, 1'b1);
        check("brk_ascii", kb.ascii, 0);
        check("brk_scan", kb.scan_code, 0);
        check("brk_kvcnt", kvCount, 1);

        sendFrame(8'h1C, 1'b0, 1'b1);
        check("a2_ascii", kb.ascii, 'h61);
        check("a2_kvcnt", kvCount, 2);
        sendFrame(8'h1C, 1'b1, 1'b1);
        check("par_cnt", peCount, 1);
        check("par_lat", peCyc - fallCyc, 2);
        check("par_ascii", kb.ascii, 'h61);
        check("par_kvcnt", kvCount, 2);

        ps2Bit(1'b1);
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("start_fecnt", feCount, 1);
        check("start_felat", feCyc - fallCyc, 2);

        ps2Bit(1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(part[i]);
        repeat (3 * FT) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("tmo_fecnt", feCount, 2);
        check("tmo_ascii", kb.ascii, 'h61);
        sendFrame(8'h32, 1'b0, 1'b1);
        check("b_ascii", kb.ascii, 'h62);
        check("b_kvcnt", kvCount, 3);

        sendFrame(8'h1C, 1'b0, 1'b1);
        check("hold_ascii", kb.ascii, 'h61);
        sendFrame(8'hE0, 1'b0, 1'b1);
        sendFrame(8'h75, 1'b0, 1'b1);
        check("ext_ascii", kb.ascii, 'h61);
        check("ext_scan", kb.scan_code, 'h1C);
        check("ext_kvcnt", kvCount, 4);
        sendFrame(8'h32, 1'b0, 1'b1);
        check("last_ascii", kb.ascii, 'h62);
        check("last_kvcnt", kvCount, 5);
        sendFrame(8'hF0, 1'b0, 1'b1);
        sendFrame(8'h1C, 1'b0, 1'b1);
        check("oldbrk_ascii", kb.ascii, 'h62);
        check("oldbrk_scan", kb.scan_code, 'h32);

        sendFrame(8'h76, 1'b0, 1'b1);
        check("unmap_ascii", kb.ascii, 'h62);
        check("unmap_kvcnt", kvCount, 5);

        sendFrame(8'h1C, 1'b0, 1'b0);
        check("stop_fecnt", feCount, 3);
        check("stop_ascii", kb.ascii, 'h62);

        ps2Bit(1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(part[i]);
        PS2_KBDAT = part[4];
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b1;
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        check("mrst_ascii", kb.ascii, 0);
        check("mrst_scan", kb.scan_code, 0);
        check("mrst_kv", kb.key_valid, 0);
        PS2_KBDAT = 1'b1;
        repeat (20) @(posedge CLOCK_50);
        sendFrame(8'h29, 1'b0, 1'b1);
        check("sp_ascii", kb.ascii, 'h20);
        check("sp_scan", kb.scan_code, 'h29);
        check("sp_kvcnt", kvCount, 6);
        check("sp_fecnt", feCount, 3);

        check("pe_total", peCount, 1);
        check("overlap", overlap, 0);
        check("width", wide, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
